// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - instruction fetch PC owner with prefetch FIFO toward decode
// Optional combinational empty-queue forwarding is enabled by defining IFQ_BYPASS_EN.
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter int          PTR_W    = $clog2(DEPTH)
) (
    input  logic             Clk,
    input  logic             Reset,
    output logic [31:0]      Address,
    input  logic [31:0]      Instruction,
    input  logic             Redirect,
    input  logic [31:0]      RedirectPC,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [31:0]      OutInstr,
    output logic [31:0]      OutPC,
    output logic [PTR_W:0]   Count
);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } state_t;

    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    logic [31:0]      instr_mem [DEPTH];
    logic [31:0]      pc_mem    [DEPTH];
    logic [31:0]      fetch_pc;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_next;
    state_t           state;
    state_t           state_next;
    logic [31:0]      hold_instr;
    logic [31:0]      hold_pc;
    logic             not_empty;
    logic             bypass;
    logic             bypass_take;
    logic             pop_q;
    logic             push;
    logic             advance;
    logic             unused_ok;

    assign unused_ok = &{1'b0, RedirectPC[1:0]};
    assign not_empty = (count != '0);

`ifdef IFQ_BYPASS_EN
    assign bypass = !not_empty & !Redirect;
`else
    assign bypass = 1'b0;
`endif

    // A forwarded word that decode takes this cycle never enters the FIFO.
    assign bypass_take = bypass & OutReady;
    assign OutValid    = bypass | (not_empty & !Redirect);
    assign pop_q       = not_empty & !Redirect & OutReady;
    assign push        = !Redirect & ((state != FULL) | pop_q) & !bypass_take;
    assign advance     = push | bypass_take;

    assign Address = fetch_pc;
    assign Count   = count;

    always_comb begin
        OutInstr = hold_instr;
        OutPC    = hold_pc;
        if (bypass) begin
            OutInstr = Instruction;
            OutPC    = fetch_pc;
        end else if (not_empty) begin
            OutInstr = instr_mem[rd_ptr];
            OutPC    = pc_mem[rd_ptr];
        end
    end

    always_comb begin
        count_next = count;
        if (Redirect)
            count_next = '0;
        else if (push && !pop_q)
            count_next = count + COUNT_ONE;
        else if (pop_q && !push)
            count_next = count - COUNT_ONE;
    end

    always_comb begin
        state_next = FILLING;
        if (count_next == '0)
            state_next = EMPTY;
        else if (count_next == FULL_COUNT)
            state_next = FULL;
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= Instruction;
            pc_mem[wr_ptr]    <= fetch_pc;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fetch_pc   <= {RESET_PC[31:2], 2'b00};
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            state      <= EMPTY;
            hold_instr <= '0;
            hold_pc    <= '0;
        end else begin
            // Outputs keep whatever they last showed once the queue drains.
            if (bypass) begin
                hold_instr <= Instruction;
                hold_pc    <= fetch_pc;
            end else if (not_empty) begin
                hold_instr <= instr_mem[rd_ptr];
                hold_pc    <= pc_mem[rd_ptr];
            end
            count <= count_next;
            state <= state_next;
            if (Redirect) begin
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                fetch_pc <= {RedirectPC[31:2], 2'b00};
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + PTR_ONE;
                if (pop_q)
                    rd_ptr <= rd_ptr + PTR_ONE;
                if (advance)
                    fetch_pc <= fetch_pc + 32'd4;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - self-checking bench for instr_fetch_queue
module tb_instr_fetch_queue;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] Address;
    logic [31:0] Instruction;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] OutInstr;
    logic [31:0] OutPC;
    logic [2:0]  Count;

    int errors = 0;
    int checks = 0;

    instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h00000000)) dut (
        .Clk(Clk), .Reset(Reset), .Address(Address), .Instruction(Instruction),
        .Redirect(Redirect), .RedirectPC(RedirectPC), .OutValid(OutValid),
        .OutReady(OutReady), .OutInstr(OutInstr), .OutPC(OutPC), .Count(Count)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr == 32'h0) return 32'h20080005;
        return (addr * 32'd2654435761) ^ 32'h5A5A0F0F;
    endfunction

    assign Instruction = mem_word(Address);

    // Reference model: queue of fetched PCs, the next fetch PC and the last shown head.
    logic [31:0] mq[$];
    logic [31:0] m_fpc;
    logic [31:0] m_last_pc;
    logic [31:0] m_last_instr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_fpc = 32'h0;
        m_last_pc = 32'h0;
        m_last_instr = 32'h0;
    endtask

    task automatic apply(input logic r, input logic [31:0] rpc, input logic rdy);
        Redirect = r;
        RedirectPC = rpc;
        OutReady = rdy;
        #2;
    endtask

    task automatic check_model();
        logic exp_valid;
        exp_valid = (mq.size() != 0) && !Redirect;
        chk("count", 32'(Count), 32'(mq.size()));
        chk("valid", 32'(OutValid), 32'(exp_valid));
        chk("address", Address, m_fpc);
        chk("out_pc", OutPC, (mq.size() != 0) ? mq[0] : m_last_pc);
        chk("out_instr", OutInstr, (mq.size() != 0) ? mem_word(mq[0]) : m_last_instr);
    endtask

    task automatic clock_model();
        logic pop;
        logic push;
        pop = (mq.size() != 0) && !Redirect && OutReady;
        push = !Redirect && ((mq.size() < 4) || pop);
        @(posedge Clk);
        if (mq.size() != 0) begin
            m_last_pc = mq[0];
            m_last_instr = mem_word(mq[0]);
        end
        if (Redirect) begin
            mq.delete();
            m_fpc = {RedirectPC[31:2], 2'b00};
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back(m_fpc);
                m_fpc = m_fpc + 32'd4;
            end
        end
        #1;
    endtask

    task automatic step(input logic r, input logic [31:0] rpc, input logic rdy);
        apply(r, rpc, rdy);
        check_model();
        clock_model();
    endtask

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        ready;
        logic [2:0]  e_count;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_addr;
    } vec_t;

    vec_t vecs[15];

    initial begin
        vecs[0]  = '{1'b0, 32'h0,  1'b0, 3'd0, 1'b0, 32'h00, 32'h00};
        vecs[1]  = '{1'b0, 32'h0,  1'b0, 3'd1, 1'b1, 32'h00, 32'h04};
        vecs[2]  = '{1'b0, 32'h0,  1'b0, 3'd2, 1'b1, 32'h00, 32'h08};
        vecs[3]  = '{1'b0, 32'h0,  1'b0, 3'd3, 1'b1, 32'h00, 32'h0C};
        vecs[4]  = '{1'b0, 32'h0,  1'b0, 3'd4, 1'b1, 32'h00, 32'h10};
        vecs[5]  = '{1'b0, 32'h0,  1'b0, 3'd4, 1'b1, 32'h00, 32'h10};
        vecs[6]  = '{1'b0, 32'h0,  1'b1, 3'd4, 1'b1, 32'h00, 32'h10};
        vecs[7]  = '{1'b0, 32'h0,  1'b1, 3'd4, 1'b1, 32'h04, 32'h14};
        vecs[8]  = '{1'b0, 32'h0,  1'b1, 3'd4, 1'b1, 32'h08, 32'h18};
        vecs[9]  = '{1'b0, 32'h0,  1'b1, 3'd4, 1'b1, 32'h0C, 32'h1C};
        vecs[10] = '{1'b0, 32'h0,  1'b1, 3'd4, 1'b1, 32'h10, 32'h20};
        vecs[11] = '{1'b1, 32'h6B, 1'b1, 3'd4, 1'b0, 32'h14, 32'h24};
        vecs[12] = '{1'b0, 32'h0,  1'b1, 3'd0, 1'b0, 32'h14, 32'h68};
        vecs[13] = '{1'b0, 32'h0,  1'b1, 3'd1, 1'b1, 32'h68, 32'h6C};
        vecs[14] = '{1'b0, 32'h0,  1'b1, 3'd1, 1'b1, 32'h6C, 32'h70};

        Reset = 1'b1;
        Redirect = 1'b0;
        RedirectPC = 32'h0;
        OutReady = 1'b0;
        model_reset();
        #6;
        chk("reset_out_instr", OutInstr, 32'h0);
        Reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            apply(vecs[i].redir, vecs[i].rpc, vecs[i].ready);
            chk($sformatf("vec%0d_count", i), 32'(Count), 32'(vecs[i].e_count));
            chk($sformatf("vec%0d_valid", i), 32'(OutValid), 32'(vecs[i].e_valid));
            chk($sformatf("vec%0d_pc", i), OutPC, vecs[i].e_pc);
            chk($sformatf("vec%0d_addr", i), Address, vecs[i].e_addr);
            if (i == 1) chk("first_instr", OutInstr, 32'h20080005);
            check_model();
            clock_model();
        end

        // Address space wrap after a redirect near the top
        step(1'b1, 32'hFFFFFFF8, 1'b1);
        for (int k = 0; k < 6; k++) begin
            apply(1'b0, 32'h0, 1'b1);
            if (k >= 1) chk($sformatf("wrap_pc%0d", k), OutPC, 32'hFFFFFFF8 + 32'(4 * (k - 1)));
            check_model();
            clock_model();
        end

        // Fill, then push and pop together while full
        for (int k = 0; k < 5; k++) step(1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 32'h0, k[0] == 1'b0);
            chk("full_count", 32'(Count), 32'd4);
        end

        // Asynchronous reset between edges while three entries are queued
        step(1'b1, 32'h400, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 32'h0, 1'b0);
        apply(1'b0, 32'h0, 1'b0);
        chk("pre_reset_count", 32'(Count), 32'd3);
        #2;
        Reset = 1'b1;
        #1;
        chk("async_reset_count", 32'(Count), 32'd0);
        chk("async_reset_valid", 32'(OutValid), 32'd0);
        chk("async_reset_addr", Address, 32'h0);
        Reset = 1'b0;
        model_reset();
        check_model();
        clock_model();

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(7) == 0), $urandom, $urandom_range(1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Initiator side of the instruction-memory read interface: owns the fetch PC and drives Address into InstructionMemory.
- Captures the combinational Instruction response into a small prefetch FIFO.
- Presents the FIFO head to decode with a valid/ready handshake.
- Sits between the PC/branch logic and the IF/ID pipeline register; a branch/jump redirect flushes the queue and restarts fetch.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- RESET_PC, 32'h00000000, fetch PC loaded on reset.
- PTR_W, $clog2(DEPTH), pointer width; derived, do not override.

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- Address  out  32  fetch address to InstructionMemory; equals the FetchPC register.
- Instruction  in  32  combinational memory response for Address, valid in the same cycle.
- Redirect  in  1  branch/jump taken; flush and restart fetch.
- RedirectPC  in  32  new fetch address; bits [1:0] ignored.
- OutValid  out  1  head entry available.
- OutReady  in  1  consumer accepts head this cycle.
- OutInstr  out  32  head instruction word.
- OutPC  out  32  address the head instruction was fetched from.
- Count  out  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (async, active-high), all of:
  - FetchPC = RESET_PC with [1:0] cleared
  - read/write pointers = 0; Count = 0
  - OutValid = 0; OutInstr = 0; OutPC = 0
- Definitions:
  - Pop = OutValid & OutReady.
  - Push = !Redirect & (Count < DEPTH | Pop). Fetch proceeds when full only if a pop frees a slot in the same cycle.
- Push, at the clock edge:
  - write {FetchPC, Instruction} at the write pointer;
  - FetchPC <= FetchPC + 4, wrapping 32'hFFFFFFFC -> 32'h00000000;
  - write pointer increments modulo DEPTH.
- Pop: read pointer increments modulo DEPTH.
- Count update: +1 on push only, -1 on pop only, unchanged on push and pop together.
- Latency:
  - A word fetched in cycle N is at the head no earlier than cycle N+1.
  - Sustained throughput is 1 instruction/cycle with OutReady held high.
- Outputs:
  - OutValid = (Count != 0) & !Redirect.
  - OutInstr/OutPC are driven combinationally from the head entry.
  - When Count == 0, OutInstr/OutPC hold their last driven values (0 after reset).
- Redirect, which has priority over everything else:
  - no push, no pop counted;
  - pointers and Count clear to 0;
  - FetchPC <= {RedirectPC[31:2], 2'b00};
  - first post-redirect instruction is valid at the head two cycles after Redirect is asserted.
- Redirect held for several cycles: the flush repeats and FetchPC tracks RedirectPC each cycle.
- State machine, held in a 2-bit state register:
  - EMPTY: Count == 0.
  - FILLING: 0 < Count < DEPTH.
  - FULL: Count == DEPTH; fetch stalls and Address holds steady.
  - Transitions follow the Count update; Redirect forces EMPTY from any state.
- Boundaries:
  - A full queue with no pop never overwrites an entry.
  - Pop with Count == 0 is impossible, because OutValid = 0.
  - The pointer wrap at DEPTH-1 -> 0 is seamless.
  - Reset asserted mid-stream discards all entries immediately, without waiting for a clock edge.

Optional Feature:
- Macro: IFQ_BYPASS_EN.
- Defined:
  - When Count == 0 and !Redirect, the memory response is forwarded combinationally: OutValid = 1, OutInstr = Instruction, OutPC = FetchPC.
  - If OutReady = 1 that cycle, the word is consumed without being written: FetchPC advances and Count stays 0.
  - Zero-cycle fetch-to-decode latency on an empty queue.
- Undefined:
  - No forwarding; the minimum latency of 1 cycle applies.

Test Plan:
- Reset release with memory word at 0x0 = 0x20080005, OutReady=1 -> cycle after first edge: OutValid=1, OutInstr=0x20080005, OutPC=0x0; then OutPC 0x4, 0x8, ... one per cycle.
- OutReady=0 for 6 cycles from reset -> Count reaches 4, Address holds 0x10, OutPC stays 0x0; then raise OutReady -> heads 0x0, 0x4, 0x8, 0xC, 0x10 in consecutive cycles with no gap or duplicate.
- Queue holding 0x8..0x14 with Redirect=1, RedirectPC=0x6B -> same cycle OutValid=0; next edge Count=0, Address=0x68; instruction at 0x68 reaches the head the following cycle.
- Push and pop together while full (DEPTH=4, OutReady toggling 1/0) -> Count stays 4 when both occur, PCs strictly +4 in order, no entry lost.
- Redirect to 0xFFFFFFF8 with OutReady=1 -> OutPC sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
- Reset pulsed asynchronously between edges while Count=3 -> Count=0, OutValid=0, Address=RESET_PC immediately; with IFQ_BYPASS_EN defined, OutValid=1 in the same cycle Reset deasserts.
